apu_cmd_seq: RTL and testbench

APU_CMD_SEQ -- requirements
Module: apu_cmd_seq

---
 rtl/apu_cmd_seq.sv | 183 ++++++++++++++++++
 tb/tb_apu_cmd_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apu_cmd_seq.sv
// ============================================================================
//  Module      : apu_cmd_seq
//  Description : Command FIFO feeding a sound-unit register-write / delay
//                sequencer (SETUP -> STROBE -> GAP write cycle, WAIT delay).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module apu_cmd_seq #(
    parameter int DEPTH         = 8,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wait,
    input  logic [7:0]               cmd_addr,
    input  logic [7:0]               cmd_data,
    output logic [15:0]              apu_a,
    output logic [7:0]               apu_din,
    output logic                     apu_wr,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   apu_a_q, apu_a_d;
    logic [7:0]    apu_din_q, apu_din_d;
    logic          err_q, err_d;

    logic          push;
    logic          pop;
    logic [16:0]   head;
    logic          head_wait;
    logic [7:0]    head_addr;
    logic [7:0]    head_data;
    logic          addr_ok;

    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_wait = head[16];
    assign head_addr = head[15:8];
    assign head_data = head[7:0];
    assign addr_ok   = (head_addr >= 8'h10) && (head_addr <= 8'h3F);

    // FIFO storage carries no reset; occupancy is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_wait, cmd_addr, cmd_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            apu_a_q   <= 16'h0000;
            apu_din_q <= 8'h00;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            apu_a_q   <= apu_a_d;
            apu_din_q <= apu_din_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // Next-state logic; cnt_q is shared by STROBE, GAP and WAIT timing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        apu_a_d   = apu_a_q;
        apu_din_d = apu_din_q;
        err_d     = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (head_wait) begin
                        state_d = ST_WAIT;
                        cnt_d   = {head_addr, head_data};
                    end else if (addr_ok) begin
                        state_d   = ST_SETUP;
                        apu_a_d   = {8'hFF, head_addr};
                        apu_din_d = head_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = 16'(STROBE_CYCLES);
            end
            ST_STROBE: begin
                if (cnt_q <= 16'd1) begin
                    state_d = ST_GAP;
                    cnt_d   = 16'(GAP_CYCLES);
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'h0000;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_WAIT: begin
                // A zero delay still spends one cycle here.
                if (cnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'h0000;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'h0000;
            end
        endcase
    end

    // Outputs
    always_comb begin
        apu_wr    = (state_q == ST_STROBE);
        busy      = (state_q != ST_IDLE) || (level_q != '0);
        cmd_ready = (level_q != LW'(DEPTH));
        level     = level_q;
        apu_a     = apu_a_q;
        apu_din   = apu_din_q;
        err       = err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_apu_cmd_seq.sv
// ============================================================================
//  Module      : tb_apu_cmd_seq
//  Description : Directed self-checking bench for apu_cmd_seq.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apu_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wait;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [15:0] apu_a;
    logic [7:0]  apu_din;
    logic        apu_wr;
    logic        busy;
    logic [3:0]  level;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] obs_q[$];
    logic        prev_wr = 1'b0;
    int          run_len = 0;
    int          bad_runs = 0;
    int          err_cycles = 0;
    int          cyc = 0;

    apu_cmd_seq #(.DEPTH(8), .STROBE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wait(cmd_wait), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .apu_a(apu_a), .apu_din(apu_din), .apu_wr(apu_wr), .busy(busy),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs each strobe's address/data and flags bad lengths
    // or values that move while the strobe is high.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr <= 1'b0;
            run_len <= 0;
        end else begin
            prev_wr <= apu_wr;
            run_len <= apu_wr ? run_len + 1 : 0;
            if (apu_wr && !prev_wr) obs_q.push_back({apu_a, apu_din});
            if (apu_wr && prev_wr && obs_q.size() > 0 && obs_q[obs_q.size()-1] != {apu_a, apu_din})
                bad_runs <= bad_runs + 1;
            if (!apu_wr && prev_wr && run_len != 2) bad_runs <= bad_runs + 1;
            if (err) err_cycles <= err_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        int i;
        cmd_valid = 1'b1;
        cmd_wait  = w;
        cmd_addr  = a;
        cmd_data  = d;
        for (i = 0; i < 200 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        int e0;
        int s0;
        logic [23:0] exp_v [8];
        exp_v = '{24'hFF3001, 24'hFF3123, 24'hFF3245, 24'hFF3367,
                  24'hFF3489, 24'hFF35AB, 24'hFF36CD, 24'hFF37EF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_wait = 1'b0; cmd_addr = 8'h00; cmd_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_apu_a", 32'(apu_a), 32'h0000);
        check("rst_apu_din", 32'(apu_din), 32'h00);
        check("rst_wr", 32'(apu_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Single write FF26=80
        push(1'b0, 8'h26, 8'h80);
        check("t1_level", 32'(level), 32'd1);
        step();
        check("t1_setup_a", 32'(apu_a), 32'hFF26);
        check("t1_setup_din", 32'(apu_din), 32'h80);
        check("t1_setup_wr", 32'(apu_wr), 32'd0);
        step(); check("t1_strobe1", 32'(apu_wr), 32'd1);
        step(); check("t1_strobe2", 32'(apu_wr), 32'd1);
        step(); check("t1_gap1", 32'(apu_wr), 32'd0);
        check("t1_gap_a", 32'(apu_a), 32'hFF26);
        step(); check("t1_gap2_busy", 32'(busy), 32'd1);
        step(); check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_hold_a", 32'(apu_a), 32'hFF26);
        check("t1_nstrobe", 32'(obs_q.size()), 32'd1);

        // Fill FIFO behind a long delay, then drain 8 writes
        obs_q.delete();
        push(1'b1, 8'h00, 8'h40);
        for (int k = 0; k < 8; k++) push(1'b0, 8'(8'h30 + k), exp_v[k][7:0]);
        check("t2_level_full", 32'(level), 32'd8);
        check("t2_ready_full", 32'(cmd_ready), 32'd0);
        wait_idle();
        check("t2_nstrobe", 32'(obs_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < obs_q.size(); k++)
            check($sformatf("t2_strobe%0d", k), 32'(obs_q[k]), 32'(exp_v[k]));
        check("t2_bad_runs", 32'(bad_runs), 32'd0);

        // Write, delay 16, write: GAP(2) + pop(1) + WAIT(16) + pop(1) = 20
        obs_q.delete();
        push(1'b0, 8'h12, 8'hF3);
        push(1'b1, 8'h00, 8'h10);
        push(1'b0, 8'h24, 8'h77);
        for (int i = 0; i < 100 && !apu_wr; i++) @(negedge clk);
        check("t3_first_wr", 32'(apu_wr), 32'd1);
        for (int i = 0; i < 100 && apu_wr; i++) @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 100 && apu_a != 16'hFF24; i++) @(negedge clk);
        check("t3_wait_span", 32'(cyc - t0), 32'd20);
        check("t3_din", 32'(apu_din), 32'h77);
        #1;
        wait_idle();
        check("t3_nstrobe", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() > 0) check("t3_first", 32'(obs_q[0]), 32'hFF12F3);

        // Out-of-range write dropped with err, valid write follows
        obs_q.delete();
        e0 = err_cycles;
        push(1'b0, 8'h05, 8'h55);
        push(1'b0, 8'h11, 8'h99);
        wait_idle();
        step();
        check("t4_err_cycles", 32'(err_cycles - e0), 32'd1);
        check("t4_nstrobe", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) check("t4_strobe", 32'(obs_q[0]), 32'hFF1199);
        check("t4_err_low", 32'(err), 32'd0);

        // Reset in the middle of a strobe with 3 entries queued
        obs_q.delete();
        for (int k = 0; k < 4; k++) push(1'b0, 8'(8'h20 + k), 8'(k));
        for (int i = 0; i < 50 && !apu_wr; i++) step();
        check("t5_in_strobe", 32'(apu_wr), 32'd1);
        check("t5_level_pre", 32'(level), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_wr", 32'(apu_wr), 32'd0);
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_ready", 32'(cmd_ready), 32'd1);
        check("t5_rst_apu_a", 32'(apu_a), 32'h0000);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = obs_q.size();
        repeat (20) step();
        check("t5_no_strobe", 32'(obs_q.size()), 32'(s0));
        check("t5_busy_after", 32'(busy), 32'd0);

        // Zero delay with a push on the pop edge
        push(1'b1, 8'h00, 8'h00);
        push(1'b0, 8'h10, 8'hAA);
        check("t6_level_pushpop", 32'(level), 32'd1);
        step();
        check("t6_wait_a", 32'(apu_a), 32'h0000);
        step();
        check("t6_setup_a", 32'(apu_a), 32'hFF10);
        check("t6_setup_din", 32'(apu_din), 32'hAA);
        wait_idle();
        check("t6_bad_runs", 32'(bad_runs), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
